// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense path.
// - state_e  : dispense controller state encoding
// - coin_e   : coin codes shared with the accumulation FSM
// - Def*     : default timing constants
// - max2     : helper for sizing timers from several parameters
package vend_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMotor,
    StWaitDrop,
    StHopOn,
    StHopGap,
    StDone,
    StFault
  } state_e;

  typedef enum logic [1:0] {
    CoinTen    = 2'b00,
    CoinTwenty = 2'b01,
    CoinFifty  = 2'b10
  } coin_e;

  localparam int unsigned DefMotorCycles = 8;
  localparam int unsigned DefDropTimeout = 64;
  localparam int unsigned DefHopperPulse = 4;
  localparam int unsigned DefHopperGap   = 4;
  localparam int unsigned DefMaxChange   = 4;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous panel sensors.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : synchronized output, lags d by two clocks
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense controller: runs the product motor, waits for the drop sensor,
// ejects owed change coins one pulse at a time and reports done or jam.
// Ports:
//   clk, reset   : clock and asynchronous active-low reset
//   vend_req     : vend strobe, sampled only while idle
//   change_req   : change owed flag, captured with vend_req
//   change_units : number of 10-unit coins owed, captured with vend_req
//   drop_sense   : asynchronous product-drop sensor
//   fault_clr    : operator clear, only acts in the fault state
//   motor_en     : product motor drive
//   hopper_en    : change hopper drive
//   busy         : high whenever not idle
//   vend_done    : one-cycle completion pulse
//   fault        : high while jammed
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned MOTOR_CYCLES = DefMotorCycles,
  parameter int unsigned DROP_TIMEOUT = DefDropTimeout,
  parameter int unsigned HOPPER_PULSE = DefHopperPulse,
  parameter int unsigned HOPPER_GAP   = DefHopperGap,
  parameter int unsigned MAX_CHANGE   = DefMaxChange
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vend_req,
  input  logic       change_req,
  input  logic [2:0] change_units,
  input  logic       drop_sense,
  input  logic       fault_clr,
  output logic       motor_en,
  output logic       hopper_en,
  output logic       busy,
  output logic       vend_done,
  output logic       fault
);

  localparam int unsigned TimerMax =
      max2(max2(MOTOR_CYCLES, DROP_TIMEOUT), max2(HOPPER_PULSE, HOPPER_GAP));
  localparam int unsigned TW = $clog2(TimerMax + 1);
  localparam logic [2:0] MaxCoins = (MAX_CHANGE > 7) ? 3'd7 : 3'(MAX_CHANGE);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    coins_q, coins_d;
  logic          drop_lat_q, drop_lat_d;
  logic          motor_q, hopper_q, busy_q, done_q, fault_q;

  logic          drop_s;
  logic [TW-1:0] timer_dec;
  logic          timer_last;
  logic [2:0]    coins_cap;

  sync2 #(
    .WIDTH(1)
  ) u_drop_sync (
    .clk  (clk),
    .reset(reset),
    .d    (drop_sense),
    .q    (drop_s)
  );

  // Timer saturates at zero; "last" covers the final counted cycle.
  assign timer_dec  = (timer_q != '0) ? timer_q - TW'(1) : '0;
  assign timer_last = (timer_q <= TW'(1));

  // A change request with zero units still pays out one coin.
  always_comb begin
    coins_cap = 3'd0;
    if (change_req) begin
      if (change_units == 3'd0) begin
        coins_cap = 3'd1;
      end else if (change_units > MaxCoins) begin
        coins_cap = MaxCoins;
      end else begin
        coins_cap = change_units;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_dec;
    coins_d    = coins_q;
    drop_lat_d = drop_lat_q;
    unique case (state_q)
      StIdle: begin
        timer_d = timer_q;
        if (vend_req) begin
          state_d    = StMotor;
          timer_d    = TW'(MOTOR_CYCLES);
          coins_d    = coins_cap;
          drop_lat_d = 1'b0;
        end
      end
      StMotor: begin
        // Product may fall before the motor stops; remember it.
        if (drop_s) drop_lat_d = 1'b1;
        if (timer_last) begin
          state_d = StWaitDrop;
          timer_d = TW'(DROP_TIMEOUT);
        end
      end
      StWaitDrop: begin
        // Drop seen on the final timeout cycle still counts as success.
        if (drop_lat_q || drop_s) begin
          if (coins_q != 3'd0) begin
            state_d = StHopOn;
            timer_d = TW'(HOPPER_PULSE);
          end else begin
            state_d = StDone;
          end
        end else if (timer_last) begin
          state_d = StFault;
          coins_d = 3'd0;
        end
      end
      StHopOn: begin
        if (timer_last) begin
          state_d = StHopGap;
          timer_d = TW'(HOPPER_GAP);
          coins_d = (coins_q != 3'd0) ? coins_q - 3'd1 : 3'd0;
        end
      end
      StHopGap: begin
        if (timer_last) begin
          if (coins_q != 3'd0) begin
            state_d = StHopOn;
            timer_d = TW'(HOPPER_PULSE);
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StFault: begin
        timer_d = timer_q;
        if (fault_clr) begin
          state_d = StIdle;
          coins_d = 3'd0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      coins_q    <= 3'd0;
      drop_lat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      coins_q    <= coins_d;
      drop_lat_q <= drop_lat_d;
    end
  end

  // Outputs are flopped from the next state so they track state_q exactly
  // while coming straight off registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      motor_q  <= 1'b0;
      hopper_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      motor_q  <= (state_d == StMotor);
      hopper_q <= (state_d == StHopOn);
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
      fault_q  <= (state_d == StFault);
    end
  end

  assign motor_en  = motor_q;
  assign hopper_en = hopper_q;
  assign busy      = busy_q;
  assign vend_done = done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl. Each vend is described by its
// request and drop timing; the expected output waveform is computed from the
// timing rules with plain arithmetic and compared cycle by cycle.
module tb_vend_dispense_ctrl;

  localparam int M   = 8;   // motor cycles
  localparam int T   = 64;  // drop timeout
  localparam int P   = 4;   // hopper pulse
  localparam int G   = 4;   // hopper gap
  localparam int MAXC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       vend_req;
  logic       change_req;
  logic [2:0] change_units;
  logic       drop_sense;
  logic       fault_clr;
  logic       motor_en;
  logic       hopper_en;
  logic       busy;
  logic       vend_done;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;
  int txn = 0;

  vend_dispense_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .vend_req    (vend_req),
    .change_req  (change_req),
    .change_units(change_units),
    .drop_sense  (drop_sense),
    .fault_clr   (fault_clr),
    .motor_en    (motor_en),
    .hopper_en   (hopper_en),
    .busy        (busy),
    .vend_done   (vend_done),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {motor_en, hopper_en, busy, vend_done, fault};
  endfunction

  // Called at a negedge with the DUT idle. drop_p < 0 means the sensor never
  // fires (jam). Cycle 0 is the first cycle after the capturing edge; a pin
  // value driven in cycle p reaches the FSM as drop_s in cycle p+2.
  task automatic run_vend(input bit creq, input logic [2:0] units, input int drop_p,
                          input int drop_w, input bit stray);
    int  n, d, done_c, fault_c, clr_c, last, per, r;
    bit  jam;
    logic [4:0] exp;
    txn++;
    n = !creq ? 0 : (units == 3'd0) ? 1 : (int'(units) > MAXC) ? MAXC : int'(units);
    jam = (drop_p < 0);
    d = jam ? -1 : ((drop_p + 2 > M) ? drop_p + 2 : M);
    per = P + G;
    done_c = d + n * per + 1;
    fault_c = M + T;
    clr_c = fault_c + int'($urandom_range(0, 5));
    last = jam ? clr_c + 1 : done_c + 1;

    vend_req = 1'b1;
    change_req = creq;
    change_units = units;
    @(posedge clk);
    @(negedge clk);
    for (int t = 0; t <= last; t++) begin
      exp = '0;
      exp[4] = (t < M);
      if (!jam && n > 0 && t > d && t <= d + n * per) begin
        r = (t - d - 1) % per;
        exp[3] = (r < P);
      end
      exp[2] = (t < last);
      exp[1] = !jam && (t == done_c);
      exp[0] = jam && (t >= fault_c) && (t <= clr_c);
      check_eq($sformatf("tx%0d cyc%0d {motor,hop,busy,done,fault}", txn, t), 32'(outs()),
               32'(exp));
      if (t == last) begin
        vend_req = 1'b0;
        drop_sense = 1'b0;
        fault_clr = 1'b0;
      end else begin
        // Requests and clears while busy must have no effect.
        vend_req = stray && ($urandom_range(0, 7) == 0);
        change_req = 1'($urandom);
        change_units = 3'($urandom);
        drop_sense = !jam && (t >= drop_p) && (t < drop_p + drop_w);
        if (jam && t >= fault_c) fault_clr = (t == clr_c);
        else fault_clr = stray && ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    vend_req = 1'b0;
    change_req = 1'b0;
    change_units = 3'd0;
    drop_sense = 1'b0;
    fault_clr = 1'b0;
    #1;
    check_eq("reset outs", 32'(outs()), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("reset held outs", 32'(outs()), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle after reset", 32'(outs()), 32'd0);

    // Directed scenarios.
    run_vend(1'b0, 3'd0, M + 1, 1, 1'b0);  // no change, drop just after motor stop
    run_vend(1'b1, 3'd3, 2, 2, 1'b1);      // 3 coins, early drop, stray requests
    run_vend(1'b1, 3'd7, 3, 1, 1'b0);      // clamped to MAXC
    run_vend(1'b1, 3'd0, M + 4, 3, 1'b0);  // zero units still pays one coin
    run_vend(1'b0, 3'd5, -1, 0, 1'b1);     // jam, then clear
    run_vend(1'b0, 3'd0, M + T - 3, 1, 1'b0); // drop seen on final timeout cycle
    run_vend(1'b1, 3'd1, M - 3, 1, 1'b0);  // drop latched on last motor cycle

    // Reset in the middle of a hopper pulse.
    vend_req = 1'b1;
    change_req = 1'b1;
    change_units = 3'd3;
    @(posedge clk);
    @(negedge clk);
    vend_req = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      drop_sense = (t >= 1 && t < 3);
      if (hopper_en) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("reached hopper before reset", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1 check_eq("async reset outs", 32'(outs()), 32'd0);
    drop_sense = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("outs in reset", 32'(outs()), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle after mid-op reset", 32'(outs()), 32'd0);
    run_vend(1'b1, 3'd2, 1, 2, 1'b0);

    // Randomized vends, each issued the cycle after the previous completes.
    for (int i = 0; i < 30; i++) begin
      bit creq;
      logic [2:0] units;
      int p, w;
      creq = ($urandom_range(0, 3) != 0);
      units = 3'($urandom);
      w = int'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) p = -1;
      else if ($urandom_range(0, 1) == 0) p = int'($urandom_range(0, M + 4));
      else p = int'($urandom_range(0, M + T - 3));
      run_vend(creq, units, p, w, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
